// File: rtl/mem_store_buffer.sv
// Posted-write store buffer in front of a single-ported memory: stores retire
// into a circular FIFO, loads bypass queued writes unless they hit a buffered word.
//
// state | meaning
// IDLE  | no memory transaction in flight
// WR    | draining the head entry, waiting for mem_ack
// RD    | load issued to memory, waiting for mem_ack
module mem_store_buffer #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 4,
  localparam int BE_W   = DATA_W / 8,
  localparam int LB     = $clog2(BE_W),
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_sync,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CW-1:0]     buf_count,
  output logic              buf_full,
  output logic              buf_empty
);

  localparam int WAW = ADDR_W - LB;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]        state;
  logic [WAW-1:0]    ent_addr  [DEPTH];
  logic [DATA_W-1:0] ent_data  [DEPTH];
  logic [BE_W-1:0]   ent_be    [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              done;
  logic              hazard;
  logic              store_req;
  logic              push;
  logic              pop;
  logic              load_go;
  logic [WAW-1:0]    cpu_waddr;
  logic              unused_addr_lsb;

  assign cpu_waddr       = cpu_addr[ADDR_W-1:LB];
  assign unused_addr_lsb = ^cpu_addr[LB-1:0];

  assign buf_full  = (buf_count == CW'(DEPTH));
  assign buf_empty = (buf_count == '0);
  assign mem_req   = (state != IDLE);

  // a simultaneous load wins; the store half of the request is dropped
  assign store_req = cpu_wr & ~cpu_rd;
  assign push      = store_req & (|cpu_be) & ~buf_full;
  assign pop       = (state == WR) & mem_ack;
  assign load_go   = (state == IDLE) & cpu_rd & ~done & ~hazard;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[PW'(i)] && (ent_addr[PW'(i)] == cpu_waddr)) hazard = 1'b1;
    end
  end

  // stall is forced low while reset is asserted so the CPU is released at once
  assign cpu_stall = reset_n & ((cpu_rd & ~done) |
                                (store_req & (|cpu_be) & buf_full) |
                                (cpu_sync & ~(buf_empty & (state == IDLE))));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ent_addr[tail] <= cpu_waddr;
      ent_data[tail] <= cpu_wdata;
      ent_be[tail]   <= cpu_be;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      cpu_rdata <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_go) begin
            state    <= RD;
            mem_we   <= 1'b0;
            mem_addr <= {cpu_waddr, {LB{1'b0}}};
            mem_be   <= '1;
          end else if (!buf_empty) begin
            state     <= WR;
            mem_we    <= 1'b1;
            mem_addr  <= {ent_addr[head], {LB{1'b0}}};
            mem_wdata <= ent_data[head];
            mem_be    <= ent_be[head];
          end
        end
        WR: begin
          if (mem_ack) state <= IDLE;
        end
        RD: begin
          if (mem_ack) begin
            state     <= IDLE;
            cpu_rdata <= mem_rdata;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: a memory responder checks every issued
// transaction against an expected queue, a load monitor checks returned data.
module tb_mem_store_buffer;

  logic        clock;
  logic        reset_n;
  logic        cpu_rd, cpu_wr, cpu_sync;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [2:0]  buf_count;
  logic        buf_full, buf_empty;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } mem_item_t;

  mem_item_t   exp_mem[$];
  logic [31:0] exp_rd[$];
  mem_item_t   mon_it;
  logic [31:0] mon_rd;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_budget = 0;
  int ack_dly = 0;
  int req_age = 0;
  int st;
  int n;
  logic [2:0] cr;

  mem_store_buffer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_sync  (cpu_sync),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .buf_count (buf_count),
    .buf_full  (buf_full),
    .buf_empty (buf_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_item_t it;
    it.we = 1'b1; it.addr = a; it.wdata = d; it.be = be; it.rdata = '0;
    exp_mem.push_back(it);
  endtask

  task automatic exp_r(input logic [31:0] a, input logic [31:0] rd);
    mem_item_t it;
    it.we = 1'b0; it.addr = a; it.wdata = '0; it.be = 4'hF; it.rdata = rd;
    exp_mem.push_back(it);
    exp_rd.push_back(rd);
  endtask

  // starts at posedge+1, ends at posedge+1 after the accepting edge
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int stalls);
    cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    stalls = 0;
    #1;
    while (cpu_stall && stalls < 200) begin tick(); #1; stalls++; end
    if (stalls >= 200) chk("store_timeout", cpu_stall, 1'b0);
    tick();
    cpu_wr = 1'b0; cpu_be = 4'h0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic also_wr, output int stalls,
                         output logic [2:0] cnt_rel);
    cpu_rd = 1'b1; cpu_wr = also_wr; cpu_addr = a;
    cpu_be = also_wr ? 4'hF : 4'h0; cpu_wdata = 32'h5555_AAAA;
    stalls = 0;
    #1;
    while (cpu_stall && stalls < 200) begin tick(); #1; stalls++; end
    if (stalls >= 200) chk("load_timeout", cpu_stall, 1'b0);
    cnt_rel = buf_count;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_be = 4'h0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(buf_empty && !mem_req) && k < 300) begin tick(); k++; end
    if (k >= 300) chk("drain_timeout", {buf_empty, mem_req}, 2'b10);
  endtask

  // memory responder and transaction scoreboard
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (reset_n && mem_req) begin
      if (ack_budget > 0 && req_age >= ack_dly) begin
        mem_ack = 1'b1;
        ack_budget--;
        req_age = 0;
        n_cmp++;
        if (exp_mem.size() == 0) begin
          n_bad++;
          mem_rdata = '0;
          $display("FAIL mem_txn: unexpected we=%0b addr=%h (t=%0t)", mem_we, mem_addr, $time);
        end else begin
          mon_it = exp_mem.pop_front();
          mem_rdata = mon_it.rdata;
          if (mem_we !== mon_it.we || mem_addr !== mon_it.addr || mem_be !== mon_it.be ||
              (mon_it.we && mem_wdata !== mon_it.wdata)) begin
            n_bad++;
            $display("FAIL mem_txn: got we=%0b addr=%h be=%h wdata=%h, expected we=%0b addr=%h be=%h wdata=%h",
                     mem_we, mem_addr, mem_be, mem_wdata, mon_it.we, mon_it.addr, mon_it.be, mon_it.wdata);
          end
        end
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end
  end

  // load data monitor: fires on the release cycle of each load
  always @(negedge clock) begin
    if (reset_n && cpu_rd && !cpu_stall) begin
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_bad++;
        $display("FAIL load_data: unexpected release, rdata=%h", cpu_rdata);
      end else begin
        mon_rd = exp_rd.pop_front();
        if (cpu_rdata !== mon_rd) begin
          n_bad++;
          $display("FAIL load_data: got %h, expected %h", cpu_rdata, mon_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_sync = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_count", buf_count, 0);
    chk("rst_empty", buf_empty, 1);
    chk("rst_full", buf_full, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", cpu_rdata, 0);
    tick(); tick();
    reset_n = 1'b1;

    // four posted writes with memory stalled, then a fifth against a full buffer
    ack_budget = 0; ack_dly = 0;
    for (int i = 0; i < 4; i++) begin
      exp_w(32'h100 + 4*i, 32'hA000_0000 + i, 4'hF);
      do_store(32'h100 + 4*i, 32'hA000_0000 + i, 4'hF, st);
      chk("fill_stall", st, 0);
    end
    chk("full_flag", buf_full, 1);
    chk("full_count", buf_count, 4);
    exp_w(32'h110, 32'hA000_0004, 4'hF);
    ack_budget = 1000;
    do_store(32'h110, 32'hA000_0004, 4'hF, st);
    chk("full_store_stall", st, 1);
    wait_idle();

    // zero byte-enable store completes without effect
    do_store(32'h180, 32'h1234_5678, 4'h0, st);
    chk("be0_stall", st, 0);
    chk("be0_count", buf_count, 0);

    // minimum load latency, unaligned byte address issues the word address
    exp_r(32'h500, 32'h0BAD_F00D);
    do_load(32'h503, 1'b0, st, cr);
    chk("load_latency", st, 2);

    // load hitting a buffered store waits for that write to drain
    ack_dly = 1;
    exp_w(32'h200, 32'hDEAD_BEEF, 4'b0011);
    do_store(32'h200, 32'hDEAD_BEEF, 4'b0011, st);
    exp_r(32'h200, 32'hCAFE_F00D);
    do_load(32'h200, 1'b0, st, cr);
    chk("hazard_stall", st, 6);
    ack_dly = 0;
    wait_idle();

    // unrelated load overtakes queued writes
    ack_budget = 0;
    exp_w(32'h300, 32'h3000_0000, 4'hF);
    exp_r(32'h400, 32'h4444_0000);
    exp_w(32'h304, 32'h3000_0004, 4'hF);
    exp_w(32'h308, 32'h3000_0008, 4'hF);
    do_store(32'h300, 32'h3000_0000, 4'hF, st);
    do_store(32'h304, 32'h3000_0004, 4'hF, st);
    do_store(32'h308, 32'h3000_0008, 4'hF, st);
    ack_budget = 1000;
    do_load(32'h400, 1'b0, st, cr);
    chk("bypass_stall", st, 3);
    chk("bypass_count", cr, 2);
    wait_idle();

    // push and pop in the same cycle, enough times to wrap the pointers
    ack_budget = 0;
    exp_w(32'h600, 32'h6000_0000, 4'hF);
    exp_w(32'h604, 32'h6000_0001, 4'hF);
    do_store(32'h600, 32'h6000_0000, 4'hF, st);
    do_store(32'h604, 32'h6000_0001, 4'hF, st);
    ack_budget = 1000;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!(mem_req && mem_we) && n < 20) begin tick(); n++; end
      chk("pp_pre_count", buf_count, 2);
      exp_w(32'h608 + 4*i, 32'h6000_0002 + i, 4'(i + 1));
      do_store(32'h608 + 4*i, 32'h6000_0002 + i, 4'(i + 1), st);
      chk("pp_count", buf_count, 2);
    end
    wait_idle();

    // sync waits for the buffer to drain and releases as it empties
    ack_budget = 0;
    exp_w(32'h700, 32'h7000_0000, 4'hF);
    exp_w(32'h704, 32'h7000_0001, 4'hC);
    do_store(32'h700, 32'h7000_0000, 4'hF, st);
    do_store(32'h704, 32'h7000_0001, 4'hC, st);
    ack_budget = 1000;
    cpu_sync = 1'b1;
    #1;
    st = 0;
    while (cpu_stall && st < 100) begin tick(); #1; st++; end
    chk("sync_stall", st, 3);
    chk("sync_empty", buf_empty, 1);
    chk("sync_idle", mem_req, 0);
    tick();
    cpu_sync = 1'b0;

    // load and store together behave as a load only
    exp_r(32'h800, 32'h8888_8888);
    do_load(32'h800, 1'b1, st, cr);
    chk("rdwr_stall", st, 2);
    chk("rdwr_count", buf_count, 0);
    wait_idle();

    // reset during an outstanding read
    ack_budget = 0;
    exp_w(32'h900, 32'h9000_0000, 4'hF);
    do_store(32'h900, 32'h9000_0000, 4'hF, st);
    do_store(32'h904, 32'h9000_0001, 4'hF, st);
    cpu_rd = 1'b1; cpu_addr = 32'hA00;
    ack_budget = 1;
    #1;
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin tick(); #1; n++; end
    chk("rst_pre_req", {mem_req, mem_we}, 2'b10);
    chk("rst_pre_count", buf_count, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_count", buf_count, 0);
    chk("rst_mid_stall", cpu_stall, 0);
    chk("rst_mid_empty", buf_empty, 1);
    exp_mem.delete();
    exp_rd.delete();
    cpu_rd = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    ack_budget = 1000;
    repeat (5) tick();
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_count", buf_count, 0);

    chk("exp_mem_left", exp_mem.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
